// File: rtl/fb_arbiter.sv
// fb_arbiter
//   Shares one single-port synchronous framebuffer RAM between the VGA
//   scan-out fetch and two game-logic requesters (renderer, readback).
//   Display fetches always take their slot. Requesters share the remaining
//   cycles round-robin, optionally only during blanking (BLANK_ONLY=1).
//
// Ports
//   clk_25mhz, reset_n        : pixel clock, async active-low reset
//   pixel_strobe, active,
//   xPos, yPos, screenEnd     : VGA timing generator inputs
//   req/we/addr/wdata 0,1     : requester access (req held until ack)
//   ack0, ack1                : one-cycle completion pulse
//   rdata                     : read data, valid while an ack is high
//   mem_en/we/addr/wdata      : RAM port controls (combinational)
//   mem_rdata                 : RAM read data, one-cycle latency
//   pix_data                  : registered pixel word for the DAC
//   frame_done                : registered copy of screenEnd
module fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int BLANK_ONLY = 0
) (
  input  logic              clk_25mhz,
  input  logic              reset_n,
  input  logic              pixel_strobe,
  input  logic              active,
  input  logic [9:0]        xPos,
  input  logic [8:0]        yPos,
  input  logic              screenEnd,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_done
);

  // Phase records what was issued to the RAM in the previous cycle, which
  // tells us how to interpret mem_rdata in the current one.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_DISP = 2'd1,
    PH_REQ0 = 2'd2,
    PH_REQ1 = 2'd3
  } phase_t;

  phase_t            phase;
  phase_t            phase_next;
  logic              last;       // requester granted most recently
  logic              last_next;
  logic              disp_slot;
  logic              req_window;
  logic [ADDR_W-1:0] y_row;
  logic [ADDR_W-1:0] x_col;
  logic [ADDR_W-1:0] disp_addr;

  // 160x120 framebuffer: each word covers a 4x4 block of screen pixels.
  assign y_row     = ADDR_W'(yPos >> 2);
  assign x_col     = ADDR_W'(xPos >> 2);
  assign disp_addr = (y_row << 7) + (y_row << 5) + x_col;

  assign disp_slot  = pixel_strobe & active & (xPos[1:0] == 2'b00);
  assign req_window = (req0 | req1) & ~((BLANK_ONLY != 0) & active);

  // Next-phase decision, round-robin grant and RAM port drive.
  always_comb begin
    phase_next = PH_IDLE;
    last_next  = last;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (disp_slot) begin
      phase_next = PH_DISP;
    end else if (req_window) begin
      // Requester 0 wins when alone, or when both ask and 1 went last.
      if (req0 && (!req1 || last)) begin
        phase_next = PH_REQ0;
        last_next  = 1'b0;
      end else begin
        phase_next = PH_REQ1;
        last_next  = 1'b1;
      end
    end else begin
      phase_next = PH_IDLE;
    end

    case (phase_next)
      PH_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      PH_REQ0: begin
        mem_en    = 1'b1;
        mem_we    = we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      PH_REQ1: begin
        mem_en    = 1'b1;
        mem_we    = we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase

    // The RAM must be quiet while reset is held, even mid-frame.
    if (!reset_n) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end else begin
      mem_en = mem_en;
    end
  end

  // Phase and round-robin pointer; reset drops any pending ack.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PH_IDLE;
      last  <= 1'b1;
    end else begin
      phase <= phase_next;
      last  <= last_next;
    end
  end

  assign ack0  = (phase == PH_REQ0);
  assign ack1  = (phase == PH_REQ1);
  assign rdata = (ack0 | ack1) ? mem_rdata : '0;

  // Pixel register: loaded after a display fetch, forced to 0 in blanking.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      pix_data <= '0;
    end else if (!active) begin
      pix_data <= '0;
    end else if (phase == PH_DISP) begin
      pix_data <= mem_rdata;
    end else begin
      pix_data <= pix_data;
    end
  end

  // One-cycle delayed end-of-frame marker.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= screenEnd;
    end
  end

endmodule
